des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//   Sequential DES key schedule; the stage that produces the subkeys the round logic's permutation network consumes.
//   Accepts a 64-bit key, applies PC-1, rotates C/D halves per round and applies PC-2.
//   Emits the 16 48-bit round subkeys one at a time over a valid/ready stream to the round datapath.
//   Encrypt order K1..K16; decrypt order K16..K1.
// PARAMETERS
//   KEY_W   64  input key width incl. 8 parity bits; only 64 supported
//   SK_W    48  subkey width (PC-2 output); only 48 supported
//   ROUNDS  16  subkeys per key; only 16 supported
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous, active-low reset
//   key_valid    in   1      key_in/decrypt valid
//   key_ready    out  1      block idle, can accept a key
//   key_in       in   KEY_W  DES key; key_in[63] = DES bit 1, key_in[0] = DES bit 64
//   decrypt      in   1      sampled with key: 0 = K1..K16, 1 = K16..K1
//   subkey_valid out  1      subkey/round_idx valid
//   subkey_ready in   1      consumer accepts current subkey
//   subkey       out  SK_W   round subkey; subkey[47] = PC-2 bit 1
//   round_idx    out  4      DES round number minus 1 of presented subkey (K1 -> 0, K16 -> 15)
//   done         out  1      one-cycle pulse after final subkey handshake
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, key_ready=1, subkey_valid=0, subkey=0, round_idx=0, done=0, C/D=0, count=0.
//   Bit numbering: DES tables are 1-based MSB-first; table entry n maps to key_in[64-n].
//   PC-1 -> 56 bits; C = first 28 (DES order), D = last 28. Parity bits (8,16,..,64) ignored.
//   Shift schedule s(i), i=1..16: 1 for i in {1,2,9,16}, else 2; sum = 28.
//   Encrypt: Ci/Di = rotl(C(i-1)/D(i-1), s(i)); Ki = PC-2(Ci||Di).
//   Decrypt: K16 = PC-2(C0||D0) since C16 = C0; then rotr by s(16), s(15), ..., s(2) for K15..K1.
//   States: IDLE, RUN.
//     IDLE: key_ready=1. key_valid&&key_ready at edge N -> latch decrypt, compute first C/D, register first subkey.
//       Result: RUN from cycle N+1 with subkey_valid=1.
//     RUN: key_ready=0; key_valid ignored; subkey, round_idx stable while subkey_valid && !subkey_ready.
//       Handshake (subkey_valid&&subkey_ready) on non-final subkey: next subkey registered; valid stays 1 (one subkey per cycle max).
//       Handshake on 16th subkey: subkey_valid=0, done=1 for next cycle only, return to IDLE (key_ready=1 that same cycle).
//   Next key accepted no earlier than the cycle done is high; no overlap with an in-flight schedule.
//   subkey keeps last value after completion; round_idx holds last value.
//   Encrypt round_idx goes 0..15; decrypt goes 15..0.
//   Counter: 4-bit subkeys-emitted count, 0..15, no wrap; final handshake detected at count==15.
//   Reset mid-schedule: immediate abort to reset values; no done pulse; partial schedule discarded.
//   subkey_ready high while subkey_valid=0 has no effect.
//   All outputs registered; no combinational path from inputs to outputs.
// TESTING
//   1. Key 133457799BBCDFF1, decrypt=0, subkey_ready=1 -> K1=1B02EFFC7072, K2=79AED9DBC9E5.
//      Continues to K16=CB3D8B0E17F5 on 16 consecutive cycles; round_idx 0..15; done pulse after K16.
//   2. Same key, decrypt=1 -> first subkey CB3D8B0E17F5 with round_idx=15, last 1B02EFFC7072 with round_idx=0; done once.
//   3. Back-pressure: subkey_ready toggles randomly on key 133457799BBCDFF1.
//      Subkey/round_idx stable while stalled; accepted sequence identical to test 1; count exactly 16.
//   4. Key_in XOR 0101010101010101 (parity bits flipped) -> subkey sequence identical to test 1.
//   5. Reset asserted after K5 handshake -> outputs at reset values asynchronously, no done.
//      New key after release restarts at K1.
//   6. key_valid held high in RUN with a different key -> ignored.
//      Second key accepted only when key_ready=1 after done; its K1 follows one cycle later.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out stream bundle for the DES key schedule.
interface des_key_schedule_if #(
  parameter int KEY_W = 64,
  parameter int SK_W  = 48
);
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic             decrypt;
  logic             subkey_valid;
  logic             subkey_ready;
  logic [SK_W-1:0]  subkey;
  logic [3:0]       round_idx;
  logic             done;

  // block side
  modport slave (
    input  key_valid, key_in, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, done
  );

  // driver / consumer side
  modport master (
    output key_valid, key_in, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on key accept, one C/D rotation per
// accepted subkey, PC-2 into a registered subkey stream (enc K1..K16, dec K16..K1).
module des_key_schedule #(
  parameter int KEY_W  = 64,
  parameter int SK_W   = 48,
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  des_key_schedule_if.slave kb
);

  // Table entries are 1-based, MSB-first DES bit numbers.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q, c_n, d_n;
  logic [55:0] cd0;
  logic        dec_q;
  logic [3:0]  cnt_q;
  logic        hs, last_hs;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int n = 0; n < 56; n++) r[55-n] = k[64-PC1[n]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c, d};
    r  = '0;
    for (int n = 0; n < 48; n++) r[47-n] = cd[56-PC2[n]];
    return r;
  endfunction

  // Rounds 1, 2, 9, 16 (0-based 0, 1, 8, 15) shift by one, the rest by two.
  function automatic logic single_step(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  assign kb.key_ready = (state == IDLE);
  assign hs           = kb.subkey_valid && kb.subkey_ready;
  assign last_hs      = hs && (cnt_q == 4'(ROUNDS - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (kb.key_valid) state_nxt = RUN;
      RUN:  if (last_hs)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next C/D: first half-pair from PC-1 on accept, otherwise one rotation step.
  // Decrypt starts at C16 = C0 and walks back with right rotations.
  always_comb begin
    cd0 = pc1(kb.key_in);
    c_n = c_q;
    d_n = d_q;
    if (state == IDLE) begin
      if (kb.decrypt) begin
        c_n = cd0[55:28];
        d_n = cd0[27:0];
      end else begin
        c_n = rotl(cd0[55:28], 1'b1);
        d_n = rotl(cd0[27:0], 1'b1);
      end
    end else if (dec_q) begin
      c_n = rotr(c_q, single_step(kb.round_idx));
      d_n = rotr(d_q, single_step(kb.round_idx));
    end else begin
      c_n = rotl(c_q, single_step(kb.round_idx + 4'd1));
      d_n = rotl(d_q, single_step(kb.round_idx + 4'd1));
    end
  end

  // datapath and stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q             <= '0;
      d_q             <= '0;
      dec_q           <= 1'b0;
      cnt_q           <= '0;
      kb.subkey_valid <= 1'b0;
      kb.subkey       <= '0;
      kb.round_idx    <= '0;
      kb.done         <= 1'b0;
    end else begin
      kb.done <= 1'b0;
      case (state)
        IDLE: if (kb.key_valid) begin
          c_q             <= c_n;
          d_q             <= d_n;
          dec_q           <= kb.decrypt;
          cnt_q           <= '0;
          kb.subkey       <= pc2(c_n, d_n);
          kb.round_idx    <= kb.decrypt ? 4'(ROUNDS - 1) : 4'd0;
          kb.subkey_valid <= 1'b1;
        end
        RUN: if (hs) begin
          if (last_hs) begin
            kb.subkey_valid <= 1'b0;
            kb.done         <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + 4'd1;
            c_q          <= c_n;
            d_q          <= d_n;
            kb.subkey    <= pc2(c_n, d_n);
            kb.round_idx <= dec_q ? kb.round_idx - 4'd1 : kb.round_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, random keys against a
// cumulative-shift reference model, back-pressure, reset abort, key overlap.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_schedule_if bus();

  des_key_schedule dut (.clk(clk), .rst_n(rst_n), .kb(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Ki straight from the definition: C0/D0 rotated left by the total shift up to round r.
  function automatic logic [47:0] model_sk(input logic [63:0] key, input int r);
    logic kbits [1:64];
    logic cd [1:56];
    logic cr [1:56];
    int tot;
    logic [47:0] sk;
    tot = 0;
    sk = '0;
    for (int n = 1; n <= 64; n++) kbits[n] = key[64-n];
    for (int j = 1; j <= 56; j++) cd[j] = kbits[T_PC1[j-1]];
    for (int i = 1; i <= r; i++) tot += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    for (int j = 1; j <= 28; j++) begin
      cr[j]    = cd[((j - 1 + tot) % 28) + 1];
      cr[28+j] = cd[28 + ((j - 1 + tot) % 28) + 1];
    end
    for (int n = 1; n <= 48; n++) sk[48-n] = cr[T_PC2[n-1]];
    return sk;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [47:0] got_sk  [16];
  logic [3:0]  got_idx [16];
  int          got_n;
  int          done_n;

  // Present a key; with hold set, key_valid stays high carrying k2 through the run.
  task automatic start_key(input logic [63:0] k, input logic dec, input bit hold,
                           input logic [63:0] k2);
    int w;
    w = 0;
    while (!bus.key_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("key_ready_before_start", 64'(bus.key_ready), 64'd1);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    bus.decrypt   = dec;
    @(posedge clk); #1;
    if (hold) begin
      bus.key_in  = k2;
      bus.decrypt = 1'b0;
    end else begin
      bus.key_valid = 1'b0;
    end
    chk("valid_after_accept", 64'(bus.subkey_valid), 64'd1);
    chk("key_ready_in_run", 64'(bus.key_ready), 64'd0);
  endtask

  // Drain a schedule; returns at the cycle done should be high.
  task automatic collect(input bit bp);
    bit          stall;
    bit          hs;
    logic [47:0] psk;
    logic [3:0]  pidx;
    int          cyc;
    stall = 0; cyc = 0; got_n = 0; done_n = 0; psk = '0; pidx = '0;
    while (got_n < 16 && cyc < 400) begin
      bus.subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        chk("stall_valid", 64'(bus.subkey_valid), 64'd1);
        chk("stall_subkey", 64'(bus.subkey), 64'(psk));
        chk("stall_idx", 64'(bus.round_idx), 64'(pidx));
      end
      hs = bus.subkey_valid && bus.subkey_ready;
      if (hs) begin
        got_sk[got_n]  = bus.subkey;
        got_idx[got_n] = bus.round_idx;
        got_n++;
      end
      stall = bus.subkey_valid && !bus.subkey_ready;
      psk   = bus.subkey;
      pidx  = bus.round_idx;
      @(posedge clk); #1;
      cyc++;
      if (bus.done) done_n++;
    end
    bus.subkey_ready = 1'b0;
    chk("subkey_count", 64'(got_n), 64'd16);
    chk("done_after_final", 64'(bus.done), 64'd1);
    chk("valid_after_final", 64'(bus.subkey_valid), 64'd0);
    chk("key_ready_at_done", 64'(bus.key_ready), 64'd1);
    chk("subkey_held", 64'(bus.subkey), 64'(got_sk[15]));
    chk("done_pulses", 64'(done_n), 64'd1);
  endtask

  task automatic check_seq(input logic [63:0] k, input logic dec, input string tag);
    int r;
    for (int i = 0; i < 16; i++) begin
      r = dec ? 16 - i : i + 1;
      chk({tag, "_subkey"}, 64'(got_sk[i]), 64'(model_sk(k, r)));
      chk({tag, "_round_idx"}, 64'(got_idx[i]), 64'(r - 1));
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] first;
    logic [3:0]  first_idx;
    logic [47:0] last;
    logic [3:0]  last_idx;
  } vec_t;

  vec_t vt [3];

  initial begin
    logic [63:0] rk;
    logic        rd;
    logic [47:0] last_sk;

    vt[0] = '{STD_KEY, 1'b0, 48'h1B02EFFC7072, 4'd0, 48'hCB3D8B0E17F5, 4'd15};
    vt[1] = '{STD_KEY, 1'b1, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};
    vt[2] = '{STD_KEY ^ 64'h0101010101010101, 1'b0, 48'h1B02EFFC7072, 4'd0,
              48'hCB3D8B0E17F5, 4'd15};

    bus.key_valid = 1'b0;
    bus.key_in = '0;
    bus.decrypt = 1'b0;
    bus.subkey_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
    chk("rst_subkey_valid", 64'(bus.subkey_valid), 64'd0);
    chk("rst_subkey", 64'(bus.subkey), 64'd0);
    chk("rst_round_idx", 64'(bus.round_idx), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // known-answer table, full-rate consumer
    for (int v = 0; v < 3; v++) begin
      start_key(vt[v].key, vt[v].dec, 1'b0, '0);
      collect(1'b0);
      chk("kat_first", 64'(got_sk[0]), 64'(vt[v].first));
      chk("kat_first_idx", 64'(got_idx[0]), 64'(vt[v].first_idx));
      chk("kat_last", 64'(got_sk[15]), 64'(vt[v].last));
      chk("kat_last_idx", 64'(got_idx[15]), 64'(vt[v].last_idx));
      if (!vt[v].dec) chk("kat_k2", 64'(got_sk[1]), 64'h79AED9DBC9E5);
      check_seq(vt[v].key, vt[v].dec, "kat");
      // ready while idle does nothing
      last_sk = bus.subkey;
      bus.subkey_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_cleared", 64'(bus.done), 64'd0);
      @(posedge clk); #1;
      chk("idle_ready_valid", 64'(bus.subkey_valid), 64'd0);
      chk("idle_ready_subkey", 64'(bus.subkey), 64'(last_sk));
      bus.subkey_ready = 1'b0;
    end

    // back-pressure on the reference key
    start_key(STD_KEY, 1'b0, 1'b0, '0);
    collect(1'b1);
    chk("bp_first", 64'(got_sk[0]), 64'h1B02EFFC7072);
    chk("bp_last", 64'(got_sk[15]), 64'hCB3D8B0E17F5);
    check_seq(STD_KEY, 1'b0, "bp");
    @(posedge clk); #1;

    // random keys, direction and stalls
    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      start_key(rk, rd, 1'b0, '0);
      collect(1'($urandom_range(0, 1)));
      check_seq(rk, rd, "rand");
      @(posedge clk); #1;
    end

    // reset after the K5 handshake
    start_key(STD_KEY, 1'b0, 1'b0, '0);
    bus.subkey_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    bus.subkey_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_key_ready", 64'(bus.key_ready), 64'd1);
    chk("abort_subkey_valid", 64'(bus.subkey_valid), 64'd0);
    chk("abort_subkey", 64'(bus.subkey), 64'd0);
    chk("abort_round_idx", 64'(bus.round_idx), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    chk("abort_done_later", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_done", 64'(bus.done), 64'd0);
    start_key(STD_KEY, 1'b0, 1'b0, '0);
    chk("restart_k1", 64'(bus.subkey), 64'h1B02EFFC7072);
    chk("restart_idx", 64'(bus.round_idx), 64'd0);
    collect(1'b0);
    check_seq(STD_KEY, 1'b0, "restart");
    @(posedge clk); #1;

    // key_valid held in RUN with another key: picked up only at done
    rk = 64'hFEDCBA9876543210;
    start_key(STD_KEY, 1'b0, 1'b1, rk);
    collect(1'b0);
    check_seq(STD_KEY, 1'b0, "hold");
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    chk("second_valid", 64'(bus.subkey_valid), 64'd1);
    chk("second_k1", 64'(bus.subkey), 64'(model_sk(rk, 1)));
    chk("second_idx", 64'(bus.round_idx), 64'd0);
    collect(1'b0);
    check_seq(rk, 1'b0, "second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
